// File: rtl/sia_wbm.sv
// Wishbone B.4 pipelined master that polls the SIA status register, drains the
// SIA receive queue into an rx stream and feeds a tx stream into the transmit queue.
module sia_wbm #(
    parameter logic [2:0] ADR_STATUS  = 3'd1,
    parameter logic [2:0] ADR_TRXDAT  = 3'd2,
    parameter int         RXNE_BIT    = 0,
    parameter int         TXNF_BIT    = 1,
    parameter int         POLL_GAP    = 8,
    parameter int         ACK_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [2:0]  adr_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [1:0]  sel_o,
    output logic [15:0] dat_o,
    input  logic [15:0] dat_i,
    input  logic        ack_i,
    input  logic        stall_i,
    output logic [15:0] rx_dat_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    input  logic [15:0] tx_dat_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        err_o
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_GAP, S_POLL_REQ, S_POLL_ACK, S_RD_REQ, S_RD_ACK, S_WR_REQ, S_WR_ACK
    } state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   dat_q, dat_d;
    logic [15:0]   rx_dat_q, rx_dat_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_ready_q, tx_ready_d;
    logic          err_q, err_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_GAP;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            gap_q      <= '0;
            tmo_q      <= '0;
            dat_q      <= '0;
            rx_dat_q   <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            dat_q      <= dat_d;
            rx_dat_q   <= rx_dat_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        dat_d      = dat_q;
        rx_dat_d   = rx_dat_q;
        rx_valid_d = rx_valid_q & ~rx_ready_i;
        tx_ready_d = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_POLL_REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            // A request entered straight from an ack spends one cycle with cyc low
            // so that consecutive bus cycles are always separated.
            S_POLL_REQ, S_RD_REQ, S_WR_REQ: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                end else if (!stall_i) begin
                    stb_d = 1'b0;
                    tmo_d = '0;
                    case (state_q)
                        S_POLL_REQ: state_d = S_POLL_ACK;
                        S_RD_REQ:   state_d = S_RD_ACK;
                        default:    state_d = S_WR_ACK;
                    endcase
                end
            end
            S_POLL_ACK, S_RD_ACK, S_WR_ACK: begin
                if (ack_i) begin
                    cyc_d = 1'b0;
                    tmo_d = '0;
                    case (state_q)
                        S_POLL_ACK: begin
                            if (dat_i[RXNE_BIT] && !rx_valid_q) begin
                                state_d = S_RD_REQ;
                            end else if (dat_i[TXNF_BIT] && tx_valid_i) begin
                                state_d = S_WR_REQ;
                                dat_d   = tx_dat_i;
                            end else begin
                                state_d = S_GAP;
                                gap_d   = GAP_LOAD;
                            end
                        end
                        S_RD_ACK: begin
                            rx_dat_d   = dat_i;
                            rx_valid_d = 1'b1;
                            state_d    = S_POLL_REQ;
                        end
                        default: begin
                            tx_ready_d = 1'b1;
                            state_d    = S_POLL_REQ;
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_GAP;
        endcase
    end

    always_comb begin
        cyc_o      = cyc_q;
        stb_o      = stb_q;
        sel_o      = cyc_q ? 2'b11 : 2'b00;
        dat_o      = dat_q;
        adr_o      = '0;
        we_o       = 1'b0;
        rx_dat_o   = rx_dat_q;
        rx_valid_o = rx_valid_q;
        tx_ready_o = tx_ready_q;
        err_o      = err_q;
        if (cyc_q) begin
            case (state_q)
                S_POLL_REQ, S_POLL_ACK: adr_o = ADR_STATUS;
                S_RD_REQ, S_RD_ACK:     adr_o = ADR_TRXDAT;
                S_WR_REQ, S_WR_ACK: begin
                    adr_o = ADR_TRXDAT;
                    we_o  = 1'b1;
                end
                default: adr_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sia_wbm.sv
// Bench for sia_wbm: a Wishbone slave model and stream scoreboards run inside a
// per-cycle tick task; decision vectors come from a table, corner cases are hand-written.
module tb_sia_wbm;

    localparam logic [2:0] SIA_ADR_STATUS = 3'd1;
    localparam logic [2:0] SIA_ADR_TRXDAT = 3'd2;
    localparam int POLL_GAP    = 8;
    localparam int ACK_TIMEOUT = 64;

    logic        clk, reset_i;
    logic [2:0]  adr_o;
    logic        we_o, cyc_o, stb_o;
    logic [1:0]  sel_o;
    logic [15:0] dat_o, dat_i;
    logic        ack_i, stall_i;
    logic [15:0] rx_dat_o;
    logic        rx_valid_o, rx_ready_i;
    logic [15:0] tx_dat_i;
    logic        tx_valid_i, tx_ready_o, err_o;

    sia_wbm #(
        .ADR_STATUS (SIA_ADR_STATUS),
        .ADR_TRXDAT (SIA_ADR_TRXDAT),
        .RXNE_BIT   (0),
        .TXNF_BIT   (1),
        .POLL_GAP   (POLL_GAP),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .adr_o(adr_o), .we_o(we_o), .cyc_o(cyc_o),
        .stb_o(stb_o), .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
        .stall_i(stall_i), .rx_dat_o(rx_dat_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .tx_dat_i(tx_dat_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] adr;
        logic       we;
        int         start;
        int         acc;
        logic [2:0] start_adr;
    } txn_t;

    typedef struct {
        logic [15:0] status;
        logic        txv;
        logic [15:0] txd;
        logic [15:0] rd;
        logic [2:0]  exp_adr;
        logic        exp_we;
    } vec_t;

    int n_checks = 0;
    int n_errs   = 0;
    int tick_n   = 0;

    txn_t        log_q[$];
    int          ack_q[$];
    logic [15:0] exp_rx[$];
    logic [15:0] exp_wr[$];
    logic [15:0] tx_q[$];

    logic [15:0] status_v = 16'h0;
    logic [15:0] rd_resp  = 16'h0;
    bit          ack_en   = 1'b1;
    int          stall_left = 0;

    bit          pend = 1'b0, pend_we = 1'b0;
    logic [2:0]  pend_adr = 3'd0;
    bit          prev_stb = 1'b0, idle_chk = 1'b0, exp_txr = 1'b0;
    int          start_cnt = 0;
    logic [2:0]  start_adr = 3'd0;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of the slave model and the stream scoreboards.
    task automatic tick();
        // The rx handshake completes on the coming edge with the values driven now.
        if (!reset_i && rx_valid_o && rx_ready_i) begin
            check("rx_pop_expected", 32'(exp_rx.size() != 0), 1);
            if (exp_rx.size() != 0) check("rx_data", 32'(rx_dat_o), 32'(exp_rx.pop_front()));
        end
        @(negedge clk);
        tick_n++;
        if (idle_chk) begin
            check("cyc_idle_after_ack", 32'(cyc_o), 0);
            idle_chk = 1'b0;
        end
        if (tx_ready_o || exp_txr) check("tx_ready_pulse", 32'(tx_ready_o), 32'(exp_txr));
        exp_txr = 1'b0;
        if (tx_ready_o && tx_q.size() != 0) void'(tx_q.pop_front());
        ack_i = 1'b0;
        dat_i = 16'h0;
        if (reset_i) begin
            pend = 1'b0;
            stall_i = 1'b0;
            exp_rx.delete();
            exp_wr.delete();
            tx_q.delete();
        end else begin
            if (pend && ack_en) begin
                ack_i = 1'b1;
                if (!pend_we) dat_i = (pend_adr == SIA_ADR_STATUS) ? status_v : rd_resp;
                if (!pend_we && pend_adr == SIA_ADR_TRXDAT) exp_rx.push_back(rd_resp);
                if (pend_we) exp_txr = 1'b1;
                ack_q.push_back(tick_n);
                pend = 1'b0;
                idle_chk = 1'b1;
            end
            if (stb_o && !prev_stb) begin
                start_cnt = tick_n;
                start_adr = adr_o;
            end
            stall_i = stb_o && (stall_left > 0);
            if (stall_i) stall_left--;
            if (stb_o && !stall_i) begin
                pend = 1'b1;
                pend_adr = adr_o;
                pend_we = we_o;
                log_q.push_back('{adr_o, we_o, start_cnt, tick_n, start_adr});
                check("sel", 32'(sel_o), 3);
                if (we_o) begin
                    check("wr_expected", 32'(exp_wr.size() != 0), 1);
                    if (exp_wr.size() != 0) check("wr_data", 32'(dat_o), 32'(exp_wr.pop_front()));
                end
            end
        end
        prev_stb = stb_o;
        tx_valid_i = (tx_q.size() != 0);
        tx_dat_i = (tx_q.size() != 0) ? tx_q[0] : 16'h0;
    endtask

    task automatic push_tx(input logic [15:0] w);
        tx_q.push_back(w);
        exp_wr.push_back(w);
        tx_valid_i = 1'b1;
        tx_dat_i = tx_q[0];
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        rx_ready_i = 1'b0;
        tick();
        check("rst_bus", 32'({adr_o, we_o, cyc_o, stb_o, sel_o, dat_o}), 0);
        check("rst_stream", 32'({rx_dat_o, rx_valid_o, tx_ready_o, err_o}), 0);
        tick();
        log_q.delete();
        ack_q.delete();
        stall_left = 0;
        ack_en = 1'b1;
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int t = 0;
        while (log_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(name, 32'(log_q.size() >= n), 1);
    endtask

    function automatic int count_txn(input logic [2:0] a, input logic w);
        int c = 0;
        foreach (log_q[k]) if (log_q[k].adr == a && log_q[k].we == w) c++;
        return c;
    endfunction

    initial begin
        int k;
        int t;
        reset_i = 1'b1; ack_i = 1'b0; stall_i = 1'b0; dat_i = 16'h0;
        rx_ready_i = 1'b0; tx_valid_i = 1'b0; tx_dat_i = 16'h0;

        vecs[0] = '{16'h0000, 1'b0, 16'h0000, 16'h0000, SIA_ADR_STATUS, 1'b0};
        vecs[1] = '{16'h0001, 1'b0, 16'h0000, 16'h1234, SIA_ADR_TRXDAT, 1'b0};
        vecs[2] = '{16'h0002, 1'b1, 16'hBEEF, 16'h0000, SIA_ADR_TRXDAT, 1'b1};
        vecs[3] = '{16'h0002, 1'b0, 16'h0000, 16'h0000, SIA_ADR_STATUS, 1'b0};
        vecs[4] = '{16'h0003, 1'b1, 16'h5A5A, 16'h0F0F, SIA_ADR_TRXDAT, 1'b0};
        vecs[5] = '{16'h0001, 1'b1, 16'h1111, 16'h8001, SIA_ADR_TRXDAT, 1'b0};
        vecs[6] = '{16'hFFFC, 1'b1, 16'h2222, 16'h0000, SIA_ADR_STATUS, 1'b0};
        vecs[7] = '{16'hFFFE, 1'b1, 16'hC3C3, 16'h0000, SIA_ADR_TRXDAT, 1'b1};

        // Reset, first poll and poll spacing with an idle SIA.
        do_reset();
        status_v = 16'h0000;
        reset_i = 1'b0;
        tick();
        check("first_cyc", 32'(cyc_o), 1);
        check("first_stb", 32'(stb_o), 1);
        check("first_adr", 32'(adr_o), 32'(SIA_ADR_STATUS));
        check("first_we", 32'(we_o), 0);
        check("first_sel", 32'(sel_o), 3);
        wait_log(2, 40, "second_poll_seen");
        if (log_q.size() >= 2 && ack_q.size() >= 1) begin
            check("second_is_poll", 32'(log_q[1].adr), 32'(SIA_ADR_STATUS));
            check("poll_gap", 32'(log_q[1].start - ack_q[0]), 32'(POLL_GAP + 1));
        end

        // Decision table: which transaction follows the first status poll.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            status_v = vecs[i].status;
            rd_resp = vecs[i].rd;
            reset_i = 1'b0;
            rx_ready_i = 1'b1;
            if (vecs[i].txv) push_tx(vecs[i].txd);
            wait_log(2, 60, $sformatf("vec%0d_seen", i));
            if (log_q.size() >= 2) begin
                check($sformatf("vec%0d_poll_adr", i), 32'(log_q[0].adr), 32'(SIA_ADR_STATUS));
                check($sformatf("vec%0d_next_adr", i), 32'(log_q[1].adr), 32'(vecs[i].exp_adr));
                check($sformatf("vec%0d_next_we", i), 32'(log_q[1].we), 32'(vecs[i].exp_we));
            end
            run(20);
            if (vecs[i].exp_we) check($sformatf("vec%0d_wr_drained", i), 32'(exp_wr.size()), 0);
        end

        // Read held while the client is not ready; no further reads until it pops.
        do_reset();
        status_v = 16'h0001;
        rd_resp = 16'hABCD;
        reset_i = 1'b0;
        run(60);
        check("rx_hold_valid", 32'(rx_valid_o), 1);
        check("rx_hold_data", 32'(rx_dat_o), 32'(16'hABCD));
        check("rx_hold_one_read", 32'(count_txn(SIA_ADR_TRXDAT, 1'b0)), 1);
        check("rx_hold_polling", 32'(count_txn(SIA_ADR_STATUS, 1'b0) >= 3), 1);
        rd_resp = 16'h5555;
        rx_ready_i = 1'b1;
        run(40);
        check("rx_resume_reads", 32'(count_txn(SIA_ADR_TRXDAT, 1'b0) >= 2), 1);

        // Stall for three cycles on the first poll.
        do_reset();
        status_v = 16'h0000;
        stall_left = 3;
        reset_i = 1'b0;
        wait_log(1, 20, "stall_accept_seen");
        if (log_q.size() >= 1) begin
            check("stall_stb_cycles", 32'(log_q[0].acc - log_q[0].start + 1), 4);
            check("stall_adr_stable", 32'(log_q[0].adr), 32'(log_q[0].start_adr));
        end
        tick();
        check("stall_stb_drop", 32'(stb_o), 0);
        check("stall_cyc_held", 32'(cyc_o), 1);

        // Missing ack: timeout, sticky error, then reset mid-cycle.
        do_reset();
        ack_en = 1'b0;
        reset_i = 1'b0;
        wait_log(1, 10, "tmo_accept_seen");
        k = (log_q.size() >= 1) ? log_q[0].acc : tick_n;
        t = 0;
        while (cyc_o && t < 120) begin
            tick();
            t++;
        end
        check("tmo_cycles", 32'(tick_n - k), 32'(ACK_TIMEOUT + 1));
        check("tmo_err_set", 32'(err_o), 1);
        run(30);
        check("tmo_err_sticky", 32'(err_o), 1);
        t = 0;
        while (!cyc_o && t < 40) begin
            tick();
            t++;
        end
        check("tmo_cyc_before_reset", 32'(cyc_o), 1);
        do_reset();
        reset_i = 1'b0;
        run(30);
        check("post_reset_err", 32'(err_o), 0);
        check("post_reset_polls", 32'(count_txn(SIA_ADR_STATUS, 1'b0) >= 2), 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/sia_wbm.md
Name: sia_wbm

Overview:
- Wishbone B.4 pipelined master that acts as the initiator for the SIA register slave. It polls the SIA status register and moves words in both directions: the SIA receive queue is drained into a valid/ready output stream, and a valid/ready input stream is pushed into the SIA transmit queue.
- Sits between the SIA Wishbone slave port and a stream client (for example a DMA engine or a UART-to-FIFO bridge), so the CPU no longer has to poll the SIA.

Parameters:
- ADR_STATUS, 3'd1, word address of the SIA status register; instantiate with SIA_ADR_STATUS.
- ADR_TRXDAT, 3'd2, word address of the SIA data register; instantiate with SIA_ADR_TRXDAT.
- RXNE_BIT, 0, status bit index meaning "receive queue not empty".
- TXNF_BIT, 1, status bit index meaning "transmit queue not full".
- POLL_GAP, 8, idle cycles between status polls when the previous poll found nothing to do (minimum 1).
- ACK_TIMEOUT, 64, maximum cycles from strobe acceptance to ack_i before the bus cycle is aborted.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- adr_o  out  3  Wishbone word address [3:1]
- we_o  out  1  write enable
- cyc_o  out  1  bus cycle
- stb_o  out  1  strobe
- sel_o  out  2  byte selects
- dat_o  out  16  write data
- dat_i  in  16  read data
- ack_i  in  1  acknowledge
- stall_i  in  1  slave stall
- rx_dat_o  out  16  received word
- rx_valid_o  out  1  rx_dat_o holds a word
- rx_ready_i  in  1  client accepts the word
- tx_dat_i  in  16  word to transmit
- tx_valid_i  in  1  tx_dat_i is valid
- tx_ready_o  out  1  one-cycle pulse: tx word consumed
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset: one clock, synchronous active-high. All outputs are 0 after reset, including adr_o, dat_o, sel_o and err_o. State goes to GAP with the gap counter set to 0, so the first poll issues on the first cycle after reset deasserts. Reset asserted mid-transaction drops cyc_o and stb_o on the next edge, discards any ack arriving later, and clears rx_valid_o.
- States: GAP, POLL_REQ, POLL_ACK, RD_REQ, RD_ACK, WR_REQ, WR_ACK.
- Request phase (any *_REQ state):
  - cyc_o=1, stb_o=1, sel_o=2'b11, with adr_o, we_o and dat_o driven.
  - The request is held unchanged while stall_i=1.
  - On the first edge with stall_i=0 the strobe is accepted: stb_o drops to 0 and the state moves to the matching *_ACK state. cyc_o stays 1.
- Ack phase (any *_ACK state):
  - Waits for ack_i. On the edge where ack_i=1, cyc_o drops to 0 and the timeout counter clears.
  - An ack_i seen in a *_REQ state is ignored.
- Timeout: the counter starts at strobe acceptance. If it reaches ACK_TIMEOUT without ack_i:
  - cyc_o drops, err_o is set, and the state moves to GAP.
  - A read that timed out leaves rx_valid_o unchanged. A write that timed out does not pulse tx_ready_o.
  - err_o is cleared only by reset.
- POLL_REQ: adr_o=ADR_STATUS, we_o=0. Ack in POLL_ACK latches status s = dat_i, then the next state is chosen:
  - RD_REQ if s[RXNE_BIT]=1 and rx_valid_o=0 (receive has priority over transmit);
  - else WR_REQ if s[TXNF_BIT]=1 and tx_valid_i=1;
  - else GAP, loading the gap counter with POLL_GAP-1.
- RD_REQ: adr_o=ADR_TRXDAT, we_o=0. The ack edge latches dat_i into rx_dat_o and sets rx_valid_o=1, then the state returns to POLL_REQ immediately with no gap.
- WR_REQ: adr_o=ADR_TRXDAT, we_o=1. dat_o is sampled from tx_dat_i on entry to WR_REQ and held until the ack. The ack edge pulses tx_ready_o for exactly one cycle, then the state moves to POLL_REQ.
  - tx_valid_i dropping after WR_REQ has been entered does not cancel the write.
- GAP: counts down, then moves to POLL_REQ.
- Receive stream: rx_valid_o clears on any cycle with rx_valid_o & rx_ready_i. Read data is never overwritten, because a read is only issued when rx_valid_o=0.
- Simultaneous events: a read ack can set rx_valid_o on the same edge as a client pop clears it only if rx_valid_o was already 0. In that case set wins, since no pop can occur while rx_valid_o=0.
- Bus cycles: exactly one outstanding transaction at a time, and cyc_o is deasserted for at least one cycle between transactions.

Test Plan:
- Reset, slave with stall_i=0 and a one-cycle ack returning status 0 → first cycle after reset: cyc_o=1, stb_o=1, adr_o=ADR_STATUS, we_o=0, sel_o=11; no read or write follows; next poll starts POLL_GAP=8 cycles after the ack.
- Status 16'h0001, then TRXDAT read returning 16'hABCD, rx_ready_i=0 → rx_dat_o=ABCD, rx_valid_o=1; later polls with RXNE=1 issue no further TRXDAT read until rx_ready_i=1.
- tx_valid_i=1 with tx_dat_i=16'hBEEF, status 16'h0002 → write to ADR_TRXDAT with dat_o=BEEF and sel_o=11; tx_ready_o is high for exactly one cycle at the ack.
- Status 16'h0003 with tx_valid_i=1 and rx_valid_o=0 → the read is issued before the write.
- stall_i=1 for 3 cycles during POLL_REQ → stb_o and adr_o are held stable for 4 cycles; stb_o drops in the cycle after stall_i falls.
- No ack_i at all → cyc_o drops ACK_TIMEOUT=64 cycles after strobe acceptance, err_o=1 and stays 1; a reset asserted during the wait clears err_o and cyc_o.
